// File: rtl/mem_wait.sv
// Word-organised, byte-addressed data memory with a valid/ready request port,
// WAIT programmable wait states and a one-cycle response pulse.
module mem_wait #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 256,
   parameter int WAIT   = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  write,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [DATA_W/8-1:0]   wstrb,
   output logic                  rsp_valid,
   output logic [DATA_W-1:0]     rdata,
   output logic                  rsp_err,
   output logic [1:0]            dbg_state
);

   localparam int B     = DATA_W / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                write_q, write_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [B-1:0]        wstrb_q, wstrb_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                rsp_err_q, rsp_err_d;
   logic                rsp_valid_q, rsp_valid_d;

   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic                accept;
   logic                commit;
   logic                cur_write;
   logic [ADDR_W-1:0]   cur_addr;
   logic [DATA_W-1:0]   cur_wdata;
   logic [B-1:0]        cur_wstrb;
   logic [ADDR_W-1:0]   word_idx;
   logic [IDX_W-1:0]    mem_idx;
   logic                misaligned;
   logic                out_of_range;
   logic                acc_err;
   logic                mem_we;

   // Handshake: a request transfers on a rising edge where req_valid and
   // req_ready are both 1; req_ready depends only on state and reset, never
   // on req_valid, and a request seen while not ready simply waits.
   assign req_ready = (state_q == IDLE) && !reset;
   assign accept    = req_valid && req_ready;

   // With WAIT == 0 the commit happens on the accept edge itself, so the
   // access is decoded from the live inputs instead of the latched copy.
   always_comb begin
      if (state_q == IDLE) begin
         cur_write = write;
         cur_addr  = addr;
         cur_wdata = wdata;
         cur_wstrb = wstrb;
      end else begin
         cur_write = write_q;
         cur_addr  = addr_q;
         cur_wdata = wdata_q;
         cur_wstrb = wstrb_q;
      end
   end

   assign word_idx     = cur_addr >> $clog2(B);
   assign mem_idx      = word_idx[IDX_W-1:0];
   assign misaligned   = (cur_addr % ADDR_W'(B)) != '0;
   assign out_of_range = word_idx >= ADDR_W'(DEPTH);
   assign acc_err      = misaligned || out_of_range;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      write_d     = write_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      rdata_d     = rdata_q;
      rsp_err_d   = rsp_err_q;
      rsp_valid_d = 1'b0;
      commit      = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               write_d = write;
               addr_d  = addr;
               wdata_d = wdata;
               wstrb_d = wstrb;
               cnt_d   = CNT_W'(WAIT);
               if (WAIT == 0) begin
                  state_d = RESP;
                  commit  = 1'b1;
               end else begin
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = RESP;
               commit  = 1'b1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (commit) begin
         rsp_valid_d = 1'b1;
         rsp_err_d   = acc_err;
         rdata_d     = (!cur_write && !acc_err) ? mem_q[mem_idx] : '0;
      end
   end

   // Reset on the commit edge suppresses the write.
   assign mem_we = commit && cur_write && !acc_err && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         write_q     <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         rdata_q     <= '0;
         rsp_err_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         write_q     <= write_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         rdata_q     <= rdata_d;
         rsp_err_q   <= rsp_err_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   // Storage has no reset so contents survive a reset pulse.
   always_ff @(posedge clk) begin
      for (int i = 0; i < B; i++) begin
         if (mem_we && cur_wstrb[i]) begin
            mem_q[mem_idx][i*8 +: 8] <= cur_wdata[i*8 +: 8];
         end
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rdata     = rdata_q;
   assign rsp_err   = rsp_err_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_wait.sv
// Directed self-checking bench for mem_wait: WAIT=2 instance plus a WAIT=0
// instance sharing the request buses.
module tb_mem_wait;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        z_req_valid = 1'b0;
   logic        write = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;

   logic        req_ready, rsp_valid, rsp_err;
   logic [31:0] rdata;
   logic [1:0]  dbg_state;
   logic        z_req_ready, z_rsp_valid, z_rsp_err;
   logic [31:0] z_rdata;
   logic [1:0]  z_dbg_state;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_q[$];

   mem_wait #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .WAIT(2)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .write(write), .addr(addr), .wdata(wdata), .wstrb(wstrb),
      .rsp_valid(rsp_valid), .rdata(rdata), .rsp_err(rsp_err), .dbg_state(dbg_state)
   );

   mem_wait #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .WAIT(0)) dut_z (
      .clk(clk), .reset(reset), .req_valid(z_req_valid), .req_ready(z_req_ready),
      .write(write), .addr(addr), .wdata(wdata), .wstrb(wstrb),
      .rsp_valid(z_rsp_valid), .rdata(z_rdata), .rsp_err(z_rsp_err), .dbg_state(z_dbg_state)
   );

   always #5 clk = ~clk;

   // Driver: called and returns at 1 time unit after a rising edge.
   // lat counts rising edges from the accept edge (inclusive) until rsp_valid is seen.
   task automatic do_req(input bit sel, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s,
                         output logic [31:0] rd, output logic er,
                         output int lat, output bit ok);
      int n;
      write = wr; addr = a; wdata = d; wstrb = s;
      ok = 1'b1; rd = '0; er = 1'b0; lat = 0; n = 0;
      while (!(sel ? z_req_ready : req_ready)) begin
         @(posedge clk); #1; n++;
         if (n > 50) begin ok = 1'b0; return; end
      end
      if (sel) z_req_valid = 1'b1; else req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0; z_req_valid = 1'b0;
      lat = 1;
      while (!(sel ? z_rsp_valid : rsp_valid)) begin
         @(posedge clk); #1; lat++;
         if (lat > 50) begin ok = 1'b0; return; end
      end
      rd = sel ? z_rdata : rdata;
      er = sel ? z_rsp_err : rsp_err;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
      checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", rsp_err); end
      checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
      checks++; if (z_req_ready !== 1'b0) begin errors++; $display("FAIL reset_z_ready got=%b exp=0", z_req_ready); end
      reset = 1'b0;
      @(posedge clk); #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got=%b exp=1", req_ready); end
   endtask

   task automatic test_write_read();
      logic [31:0] rd; logic er; int lat; bit ok;
      do_req(0, 1'b1, 32'd16, 32'h0000_0014, 4'hF, rd, er, lat, ok);
      checks++; if (!ok || lat !== 3) begin errors++; $display("FAIL wr16_latency got=%0d exp=3 ok=%0d", lat, ok); end
      checks++; if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL wr16_rsp got err=%b rdata=%h exp err=0 rdata=0", er, rd); end
      do_req(0, 1'b0, 32'd16, 32'h0, 4'h0, rd, er, lat, ok);
      checks++; if (!ok || lat !== 3) begin errors++; $display("FAIL rd16_latency got=%0d exp=3 ok=%0d", lat, ok); end
      checks++; if (er !== 1'b0 || rd !== 32'h0000_0014) begin errors++; $display("FAIL rd16_data got err=%b rdata=%h exp err=0 rdata=00000014", er, rd); end
   endtask

   task automatic test_misaligned();
      logic [31:0] rd; logic er; int lat; bit ok;
      do_req(0, 1'b1, 32'd19, 32'd20, 4'hF, rd, er, lat, ok);
      checks++; if (!ok || er !== 1'b1) begin errors++; $display("FAIL wr19_err got=%b exp=1 ok=%0d", er, ok); end
      do_req(0, 1'b0, 32'd19, 32'h0, 4'h0, rd, er, lat, ok);
      checks++; if (!ok || er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL rd19 got err=%b rdata=%h exp err=1 rdata=0", er, rd); end
      do_req(0, 1'b0, 32'd16, 32'h0, 4'h0, rd, er, lat, ok);
      checks++; if (!ok || er !== 1'b0 || rd !== 32'h0000_0014) begin errors++; $display("FAIL rd16_after_misaligned got err=%b rdata=%h exp err=0 rdata=00000014", er, rd); end
   endtask

   task automatic test_strobes();
      logic [31:0] rd; logic er; int lat; bit ok;
      do_req(0, 1'b1, 32'd20, 32'hAABB_CCDD, 4'hF, rd, er, lat, ok);
      do_req(0, 1'b1, 32'd20, 32'h1122_3344, 4'h5, rd, er, lat, ok);
      checks++; if (!ok || er !== 1'b0) begin errors++; $display("FAIL strobe5_err got=%b exp=0", er); end
      do_req(0, 1'b0, 32'd20, 32'h0, 4'h0, rd, er, lat, ok);
      checks++; if (!ok || rd !== 32'hAA22_CC44) begin errors++; $display("FAIL strobe5_data got=%h exp=aa22cc44", rd); end
      do_req(0, 1'b1, 32'd20, 32'h5555_5555, 4'h0, rd, er, lat, ok);
      checks++; if (!ok || er !== 1'b0) begin errors++; $display("FAIL strobe0_err got=%b exp=0", er); end
      do_req(0, 1'b0, 32'd20, 32'h0, 4'h0, rd, er, lat, ok);
      checks++; if (!ok || rd !== 32'hAA22_CC44) begin errors++; $display("FAIL strobe0_data got=%h exp=aa22cc44", rd); end
   endtask

   task automatic test_out_of_range();
      logic [31:0] rd; logic er; int lat; bit ok;
      do_req(0, 1'b0, 32'd1024, 32'h0, 4'h0, rd, er, lat, ok);
      checks++; if (!ok || er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL rd1024 got err=%b rdata=%h exp err=1 rdata=0", er, rd); end
      do_req(0, 1'b1, 32'd1020, 32'hCAFE_F00D, 4'hF, rd, er, lat, ok);
      checks++; if (!ok || er !== 1'b0) begin errors++; $display("FAIL wr1020_err got=%b exp=0", er); end
      do_req(0, 1'b0, 32'd1020, 32'h0, 4'h0, rd, er, lat, ok);
      checks++; if (!ok || er !== 1'b0 || rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL rd1020 got err=%b rdata=%h exp err=0 rdata=cafef00d", er, rd); end
      // Word 256 would alias word 0 if the range check leaked into the write path.
      do_req(0, 1'b1, 32'd0, 32'h0102_0304, 4'hF, rd, er, lat, ok);
      do_req(0, 1'b1, 32'd1024, 32'hFFFF_FFFF, 4'hF, rd, er, lat, ok);
      checks++; if (!ok || er !== 1'b1) begin errors++; $display("FAIL wr1024_err got=%b exp=1", er); end
      do_req(0, 1'b0, 32'd0, 32'h0, 4'h0, rd, er, lat, ok);
      checks++; if (!ok || rd !== 32'h0102_0304) begin errors++; $display("FAIL rd0_no_alias got=%h exp=01020304", rd); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd; logic er; int lat; bit ok; int n; int pulses;
      do_req(0, 1'b1, 32'd24, 32'h0, 4'hF, rd, er, lat, ok);
      for (int k = 0; k < 2; k++) begin
         write = 1'b1; addr = 32'd24; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
         n = 0;
         while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
         req_valid = 1'b1;
         @(posedge clk); #1;
         req_valid = 1'b0;
         checks++; if (dbg_state !== 2'd1) begin errors++; $display("FAIL mid%0d_busy got=%0d exp=1", k, dbg_state); end
         // k=0: reset in the first BUSY cycle; k=1: reset on the commit edge.
         if (k == 1) begin @(posedge clk); #1; end
         reset = 1'b1;
         @(posedge clk); #1;
         reset = 1'b0;
         checks++; if (dbg_state !== 2'd0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL mid%0d_after_reset got state=%0d rsp_valid=%b exp state=0 rsp_valid=0", k, dbg_state, rsp_valid); end
         pulses = 0;
         repeat (6) begin @(posedge clk); #1; if (rsp_valid) pulses++; end
         checks++; if (pulses !== 0) begin errors++; $display("FAIL mid%0d_no_rsp got=%0d pulses exp=0", k, pulses); end
         do_req(0, 1'b0, 32'd24, 32'h0, 4'h0, rd, er, lat, ok);
         checks++; if (!ok || rd !== 32'h0) begin errors++; $display("FAIL mid%0d_rd24 got=%h exp=00000000", k, rd); end
      end
   endtask

   task automatic test_back_to_back();
      int acc_t[$];
      int bad_ready = 0;
      int n_rsp = 0;
      logic prev_rsp = 1'b0;
      logic [31:0] exp_v;
      write = 1'b0; addr = 32'd16; wdata = 32'h0; wstrb = 4'h0;
      req_valid = 1'b1;
      for (int i = 0; i < 18; i++) begin
         if (req_ready) begin acc_t.push_back(i); exp_q.push_back(32'h0000_0014); end
         if (dbg_state != 2'd0 && req_ready) bad_ready++;
         @(posedge clk); #1;
         if (rsp_valid) begin
            n_rsp++;
            exp_v = exp_q.pop_front();
            checks++; if (rdata !== exp_v || prev_rsp) begin errors++; $display("FAIL b2b_rsp%0d got=%h prev_rsp=%b exp=%h single pulse", n_rsp, rdata, prev_rsp, exp_v); end
         end
         prev_rsp = rsp_valid;
      end
      req_valid = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         if (rsp_valid) begin
            exp_v = exp_q.pop_front();
            checks++; if (rdata !== exp_v) begin errors++; $display("FAIL b2b_drain got=%h exp=%h", rdata, exp_v); end
         end
      end
      checks++; if (bad_ready !== 0) begin errors++; $display("FAIL b2b_ready_busy got=%0d exp=0", bad_ready); end
      checks++; if (acc_t.size() !== 5) begin errors++; $display("FAIL b2b_accepts got=%0d exp=5", acc_t.size()); end
      for (int j = 1; j < acc_t.size(); j++) begin
         checks++; if (acc_t[j] - acc_t[j-1] !== 4) begin errors++; $display("FAIL b2b_gap%0d got=%0d exp=4", j, acc_t[j] - acc_t[j-1]); end
      end
      checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL b2b_lost got=%0d pending exp=0", exp_q.size()); end
   endtask

   task automatic test_wait0();
      logic [31:0] rd; logic er; int lat; bit ok;
      do_req(1, 1'b1, 32'd8, 32'h1234_5678, 4'hF, rd, er, lat, ok);
      checks++; if (!ok || lat !== 1 || er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL w0_write got lat=%0d err=%b rdata=%h exp lat=1 err=0 rdata=0", lat, er, rd); end
      do_req(1, 1'b0, 32'd8, 32'h0, 4'h0, rd, er, lat, ok);
      checks++; if (!ok || lat !== 1 || er !== 1'b0 || rd !== 32'h1234_5678) begin errors++; $display("FAIL w0_read got lat=%0d err=%b rdata=%h exp lat=1 err=0 rdata=12345678", lat, er, rd); end
      do_req(1, 1'b0, 32'd9, 32'h0, 4'h0, rd, er, lat, ok);
      checks++; if (!ok || lat !== 1 || er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL w0_misaligned got lat=%0d err=%b rdata=%h exp lat=1 err=1 rdata=0", lat, er, rd); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_misaligned();
      test_strobes();
      test_out_of_range();
      test_reset_mid();
      test_back_to_back();
      test_wait0();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_wait.md
Name: mem_wait

Overview:
- Parametrised, word-organised, byte-addressed data memory with a valid/ready request port and a one-cycle response pulse.
- Successor to the plain single-cycle read/write memory model used by the datapath labs.
- Adds configurable data width, depth and wait states, byte-lane write strobes, and a synchronous reset.
- Misaligned or out-of-range accesses are reported through an error flag and never corrupt memory.

Parameters:
- DATA_W, 32: data word width in bits; multiple of 8, at least 8.
- ADDR_W, 32: byte address width.
- DEPTH, 256: number of words.
- WAIT, 2: extra wait cycles per access; legal range 0..15.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- write  input  1  1 = write, 0 = read; sampled at accept.
- addr  input  ADDR_W  byte address; sampled at accept.
- wdata  input  DATA_W  write data; sampled at accept.
- wstrb  input  DATA_W/8  byte-lane write enables; bit i selects byte i; sampled at accept.
- rsp_valid  output  1  one-cycle response pulse.
- rdata  output  DATA_W  read data; valid while rsp_valid is 1.
- rsp_err  output  1  access error; valid while rsp_valid is 1.

Behaviour:
- Address decode:
  - B = DATA_W/8 bytes per word.
  - Word index = addr >> log2(B).
  - Misaligned when addr mod B != 0.
  - Out of range when word index >= DEPTH.
  - Error = misaligned OR out of range.
- FSM states: IDLE, BUSY, RESP.
- req_ready = 1 only in IDLE with reset low; it is combinational from state and reset.
- Accept: req_valid & req_ready at a rising edge. At that edge, latch write, addr, wdata and wstrb, and load the wait counter with WAIT.
- IDLE transitions:
  - On accept, go to BUSY if WAIT > 0.
  - On accept, go to RESP if WAIT == 0.
  - Otherwise stay in IDLE.
- BUSY: decrement the counter each cycle. On the edge where the counter is 1, go to RESP.
- Commit edge = the edge entering RESP. On that edge:
  - Write without error: bytes with wstrb set are updated; other bytes are unchanged; wstrb = 0 leaves memory unchanged with rsp_err = 0.
  - Read without error: rdata is loaded with the addressed word.
  - Any error: memory is unchanged, rdata = 0, rsp_err = 1.
  - Write without error: rdata = 0.
- RESP: rsp_valid = 1 for exactly one cycle, then go to IDLE. No request is accepted in RESP.
- Latency: rsp_valid rises WAIT+1 cycles after the accept edge. Throughput is one request per WAIT+2 cycles.
- rdata and rsp_err hold their values until the next commit; they are only meaningful while rsp_valid is 1.
- A request held on req_valid while not in IDLE is not accepted and not lost. It is accepted on the first cycle back in IDLE if still asserted.
- Reset:
  - Forces state IDLE, counter 0, rsp_valid 0, rdata 0, rsp_err 0.
  - req_ready = 0 while reset is high.
  - Memory contents are not cleared.
- Reset mid-operation: the in-flight transaction is dropped and produces no response. If reset is high on the commit edge, the write is not committed; reset wins over commit.
- Reads return the stored value, including data written by the immediately preceding transaction.

Test Plan (DATA_W=32, DEPTH=256, WAIT=2 unless stated):
1. Aligned write then read:
   - Write addr=16, wdata=0x00000014, wstrb=0xF, then read addr=16.
   - Each rsp_valid rises 3 cycles after accept; read returns rdata=0x00000014 with rsp_err=0.
2. Misaligned accesses:
   - Write addr=19, wdata=20 → rsp_err=1.
   - Read addr=19 → rsp_err=1, rdata=0.
   - Read addr=16 → still 0x00000014.
3. Byte strobes:
   - Write addr=20, 0xAABBCCDD, wstrb=0xF.
   - Write addr=20, 0x11223344, wstrb=0x5.
   - Read addr=20 → 0xAA22CC44.
   - Write with wstrb=0x0 → rsp_err=0, data unchanged.
4. Out of range:
   - Read addr=1024 → rsp_err=1.
   - Read addr=1020 → rsp_err=0.
5. Reset mid-operation:
   - Addr 24 holds 0x0; accept write addr=24 of 0xDEADBEEF.
   - Assert reset for 1 cycle while in BUSY.
   - No rsp_valid appears; a later read of addr=24 returns 0x00000000.
6. Handshake and latency:
   - Hold req_valid high continuously → req_ready is 0 in BUSY/RESP and accepts occur every 4 cycles.
   - WAIT=0 build: rsp_valid rises 1 cycle after accept.
